mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between two requesters: port 0 is the multi-cycle CPU, port 1 is the debug/program loader.
- Runs one memory transaction at a time through a small FSM, latches the request, drives the memory strobes, waits out the read latency, then returns a one-cycle ready/rvalid pulse to the granted port.
- Sits between the CPU's memory address/write-data mux and the memory instance. The CPU controller stalls on `m0_ready`.

---
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port: request/write/address/data in, ready/rvalid/rdata back.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester (CPU or loader) side.
  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified instruction/data memory. Port 0 is the CPU,
// port 1 the debug/program loader. One transaction at a time: latch, strobe,
// wait out the read latency, then pulse ready/rvalid on the granted port.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,  // 1..7
  parameter int unsigned FIXED_PRIO = 0   // 0: round-robin, 1: port 1 wins ties
) (
  input  logic                clk,
  input  logic                reset,      // synchronous, active low
  mem_port_arbiter_if.slave   m0,
  mem_port_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [2:0] CntInit = 3'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              sel;
  logic              capture;

  // Next-state: arbitration, request latching, latency count, read-data capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    sel          = 1'b0;
    capture      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m0.req || m1.req) begin
          if (m0.req && m1.req) begin
            sel = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
          end else begin
            sel = m1.req;
          end
          grant_id_d = sel;
          we_d       = sel ? m1.we    : m0.we;
          addr_d     = sel ? m1.addr  : m0.addr;
          wdata_d    = sel ? m1.wdata : m0.wdata;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          cnt_d = CntInit;
          if (RD_LAT == 1) begin
            capture = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Counter hits zero on this decrement: data is valid now.
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        last_grant_d = grant_id_q;
        state_d      = StIdle;
      end
    endcase

    if (capture) begin
      if (grant_id_q) begin
        rdata1_d = mem_rdata;
      end else begin
        rdata0_d = mem_rdata;
      end
    end
  end

  // State register with synchronous active-low reset; aborts any transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;  // port 0 wins the first round-robin tie
      grant_id_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Outputs decoded from state and the latched request.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_read  = (state_q == StIssue) && !we_q;
    mem_write = (state_q == StIssue) && we_q;
    busy      = (state_q != StIdle);
    grant_id  = grant_id_q;
  end

  assign m0.ready  = (state_q == StResp) && !grant_id_q;
  assign m0.rvalid = (state_q == StResp) && !grant_id_q && !we_q;
  assign m0.rdata  = rdata0_q;
  assign m1.ready  = (state_q == StResp) && grant_id_q;
  assign m1.rvalid = (state_q == StResp) && grant_id_q && !we_q;
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (round-robin RD_LAT=1, fixed-priority
// RD_LAT=1, round-robin RD_LAT=3), each with a latency-accurate memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [2:0][31:0] mem_addr_a;
  logic [2:0][31:0] mem_wdata_a;
  logic [2:0][31:0] mem_rdata_a;
  logic [2:0]       mem_read_a;
  logic [2:0]       mem_write_a;
  logic [2:0]       busy_a;
  logic [2:0]       grant_a;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_rr ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_rr ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_fp ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_fp ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_l3 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_l3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset), .m0(p0_rr), .m1(p1_rr),
    .mem_addr(mem_addr_a[0]), .mem_wdata(mem_wdata_a[0]), .mem_read(mem_read_a[0]),
    .mem_write(mem_write_a[0]), .mem_rdata(mem_rdata_a[0]), .busy(busy_a[0]),
    .grant_id(grant_a[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset), .m0(p0_fp), .m1(p1_fp),
    .mem_addr(mem_addr_a[1]), .mem_wdata(mem_wdata_a[1]), .mem_read(mem_read_a[1]),
    .mem_write(mem_write_a[1]), .mem_rdata(mem_rdata_a[1]), .busy(busy_a[1]),
    .grant_id(grant_a[1])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .FIXED_PRIO(0)) u_l3 (
    .clk(clk), .reset(reset), .m0(p0_l3), .m1(p1_l3),
    .mem_addr(mem_addr_a[2]), .mem_wdata(mem_wdata_a[2]), .mem_read(mem_read_a[2]),
    .mem_write(mem_write_a[2]), .mem_rdata(mem_rdata_a[2]), .busy(busy_a[2]),
    .grant_id(grant_a[2])
  );

  // Memory models: word j holds 0x5A5A0000|j, 0x10 holds 0xDEADBEEF. Read data
  // is valid only in the cycle RD_LAT-1 after the strobe, garbage otherwise.
  for (genvar g = 0; g < 3; g++) begin : g_mem
    localparam int unsigned Lat = (g == 2) ? 3 : 1;
    logic [31:0] mem [256];
    logic [7:0]  rd_sh;
    logic        vld;
    always @(posedge clk) begin
      if (!reset) begin
        for (int j = 0; j < 256; j++) mem[j] <= 32'h5A5A_0000 | 32'(j);
        mem[16] <= 32'hDEAD_BEEF;
        rd_sh   <= 8'h00;
      end else begin
        rd_sh <= {rd_sh[6:0], mem_read_a[g]};
        if (mem_write_a[g]) mem[mem_addr_a[g][7:0]] <= mem_wdata_a[g];
      end
    end
    if (Lat == 1) begin : g_l1
      assign vld = mem_read_a[g];
    end else begin : g_ln
      assign vld = rd_sh[Lat-2];
    end
    assign mem_rdata_a[g] = vld ? mem[mem_addr_a[g][7:0]] : 32'hBAD0_BAD0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, grant_a, mem_read_a, mem_write_a} !== 12'h000) begin
      failures++;
      $display("FAIL reset_ctrl got=%h required=000", {busy_a, grant_a, mem_read_a, mem_write_a});
    end
    checks++;
    if ({p0_rr.ready, p0_rr.rvalid, p1_rr.ready, p1_rr.rvalid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_resp got=%b required=0000",
               {p0_rr.ready, p0_rr.rvalid, p1_rr.ready, p1_rr.rvalid});
    end
    checks++;
    if (mem_addr_a[0] !== 32'h0 || mem_wdata_a[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h required=0/0", mem_addr_a[0], mem_wdata_a[0]);
    end
    checks++;
    if (p0_rr.rdata !== 32'h0 || p1_rr.rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h required=0/0", p0_rr.rdata, p1_rr.rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_a !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b required=000", busy_a);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);  // cycle t
    p0_rr.req = 1'b1; p0_rr.we = 1'b0; p0_rr.addr = 32'h10;
    @(negedge clk);  // t+1
    checks++;
    if ({mem_read_a[0], mem_write_a[0], busy_a[0], p0_rr.ready} !== 4'b1010) begin
      failures++;
      $display("FAIL rd_issue got=%b required=1010",
               {mem_read_a[0], mem_write_a[0], busy_a[0], p0_rr.ready});
    end
    checks++;
    if (mem_addr_a[0] !== 32'h10) begin
      failures++;
      $display("FAIL rd_addr got=%h required=00000010", mem_addr_a[0]);
    end
    @(negedge clk);  // t+2
    checks++;
    if ({mem_read_a[0], p0_rr.ready, p0_rr.rvalid, p1_rr.ready, p1_rr.rvalid} !== 5'b01100) begin
      failures++;
      $display("FAIL rd_resp got=%b required=01100",
               {mem_read_a[0], p0_rr.ready, p0_rr.rvalid, p1_rr.ready, p1_rr.rvalid});
    end
    checks++;
    if (p0_rr.rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_data got=%h required=deadbeef", p0_rr.rdata);
    end
    p0_rr.req = 1'b0;
    @(negedge clk);  // t+3
    checks++;
    if ({busy_a[0], p0_rr.ready} !== 2'b00) begin
      failures++;
      $display("FAIL rd_done got=%b required=00", {busy_a[0], p0_rr.ready});
    end
  endtask

  task automatic test_write();
    @(negedge clk);  // t
    p1_rr.req = 1'b1; p1_rr.we = 1'b1; p1_rr.addr = 32'h20; p1_rr.wdata = 32'h1234_5678;
    @(negedge clk);  // t+1
    checks++;
    if ({mem_write_a[0], mem_read_a[0], grant_a[0]} !== 3'b101) begin
      failures++;
      $display("FAIL wr_issue got=%b required=101",
               {mem_write_a[0], mem_read_a[0], grant_a[0]});
    end
    checks++;
    if (mem_addr_a[0] !== 32'h20 || mem_wdata_a[0] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL wr_bus got=%h/%h required=00000020/12345678",
               mem_addr_a[0], mem_wdata_a[0]);
    end
    @(negedge clk);  // t+2
    checks++;
    if ({p1_rr.ready, p1_rr.rvalid, p0_rr.ready, p0_rr.rvalid} !== 4'b1000) begin
      failures++;
      $display("FAIL wr_resp got=%b required=1000",
               {p1_rr.ready, p1_rr.rvalid, p0_rr.ready, p0_rr.rvalid});
    end
    p1_rr.req = 1'b0;
    @(negedge clk);  // idle
    p1_rr.req = 1'b1; p1_rr.we = 1'b0; p1_rr.addr = 32'h20;
    repeat (2) @(negedge clk);
    checks++;
    if ({p1_rr.ready, p1_rr.rvalid} !== 2'b11 || p1_rr.rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL wr_readback got=%b/%h required=11/12345678",
               {p1_rr.ready, p1_rr.rvalid}, p1_rr.rdata);
    end
    p1_rr.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n;
    int exp_n;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    p0_rr.req = 1'b1; p0_rr.we = 1'b0; p0_rr.addr = 32'h10;
    p1_rr.req = 1'b1; p1_rr.we = 1'b0; p1_rr.addr = 32'h05;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(p0_rr.ready || p1_rr.ready) && n < 8);
      exp_n = (k == 0) ? 2 : 3;
      checks++;
      if (n !== exp_n) begin
        failures++;
        $display("FAIL rr_spacing[%0d] got=%0d cycles required=%0d", k, n, exp_n);
      end
      checks++;
      if ({p1_rr.ready, p0_rr.ready, p1_rr.rvalid, p0_rr.rvalid} !==
          (((k % 2) == 1) ? 4'b1010 : 4'b0101)) begin
        failures++;
        $display("FAIL rr_grant[%0d] got=%b required=%b", k,
                 {p1_rr.ready, p0_rr.ready, p1_rr.rvalid, p0_rr.rvalid},
                 (((k % 2) == 1) ? 4'b1010 : 4'b0101));
      end
      checks++;
      if (((k % 2) == 1) ? (p1_rr.rdata !== 32'h5A5A_0005) : (p0_rr.rdata !== 32'hDEAD_BEEF))
      begin
        failures++;
        $display("FAIL rr_data[%0d] got=%h/%h", k, p0_rr.rdata, p1_rr.rdata);
      end
    end
    p0_rr.req = 1'b0; p1_rr.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int n;
    int exp_n;
    @(negedge clk);
    p0_fp.req = 1'b1; p0_fp.we = 1'b0; p0_fp.addr = 32'h10;
    p1_fp.req = 1'b1; p1_fp.we = 1'b0; p1_fp.addr = 32'h05;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(p0_fp.ready || p1_fp.ready) && n < 8);
      exp_n = (k == 0) ? 2 : 3;
      checks++;
      if (n !== exp_n) begin
        failures++;
        $display("FAIL fp_spacing[%0d] got=%0d cycles required=%0d", k, n, exp_n);
      end
      checks++;
      if ({p1_fp.ready, p0_fp.ready, p1_fp.rvalid, p0_fp.rvalid} !==
          ((k < 3) ? 4'b1010 : 4'b0101)) begin
        failures++;
        $display("FAIL fp_grant[%0d] got=%b required=%b", k,
                 {p1_fp.ready, p0_fp.ready, p1_fp.rvalid, p0_fp.rvalid},
                 ((k < 3) ? 4'b1010 : 4'b0101));
      end
      if (k == 2) p1_fp.req = 1'b0;
    end
    checks++;
    if (p0_fp.rdata !== 32'hDEAD_BEEF || p1_fp.rdata !== 32'h5A5A_0005) begin
      failures++;
      $display("FAIL fp_data got=%h/%h required=deadbeef/5a5a0005", p0_fp.rdata, p1_fp.rdata);
    end
    p0_fp.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency3();
    @(negedge clk);  // t
    p0_l3.req = 1'b1; p0_l3.we = 1'b0; p0_l3.addr = 32'h10;
    @(negedge clk);  // t+1
    checks++;
    if (mem_read_a[2] !== 1'b1 || mem_addr_a[2] !== 32'h10) begin
      failures++;
      $display("FAIL l3_issue got=%b/%h required=1/00000010", mem_read_a[2], mem_addr_a[2]);
    end
    // Late changes after grant must not affect the transaction.
    p0_l3.addr = 32'h99; p0_l3.req = 1'b0;
    @(negedge clk);  // t+2
    checks++;
    if ({mem_read_a[2], p0_l3.ready, busy_a[2]} !== 3'b001 || mem_addr_a[2] !== 32'h10) begin
      failures++;
      $display("FAIL l3_wait1 got=%b/%h required=001/00000010",
               {mem_read_a[2], p0_l3.ready, busy_a[2]}, mem_addr_a[2]);
    end
    @(negedge clk);  // t+3
    checks++;
    if ({mem_read_a[2], p0_l3.ready, p0_l3.rvalid} !== 3'b000) begin
      failures++;
      $display("FAIL l3_wait2 got=%b required=000",
               {mem_read_a[2], p0_l3.ready, p0_l3.rvalid});
    end
    @(negedge clk);  // t+4
    checks++;
    if ({p0_l3.ready, p0_l3.rvalid, p1_l3.ready} !== 3'b110) begin
      failures++;
      $display("FAIL l3_resp got=%b required=110", {p0_l3.ready, p0_l3.rvalid, p1_l3.ready});
    end
    checks++;
    if (p0_l3.rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL l3_data got=%h required=deadbeef", p0_l3.rdata);
    end
    @(negedge clk);
    checks++;
    if (busy_a[2] !== 1'b0) begin
      failures++;
      $display("FAIL l3_idle got=%b required=0", busy_a[2]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    @(negedge clk);  // t
    p0_l3.req = 1'b1; p0_l3.we = 1'b0; p0_l3.addr = 32'h10;
    @(negedge clk);  // t+1 issue
    @(negedge clk);  // t+2 wait
    reset = 1'b0;
    @(negedge clk);  // t+3
    checks++;
    if ({busy_a[2], grant_a[2], mem_read_a[2], mem_write_a[2], p0_l3.ready, p0_l3.rvalid}
        !== 6'b000000) begin
      failures++;
      $display("FAIL abort_ctrl got=%b required=000000",
               {busy_a[2], grant_a[2], mem_read_a[2], mem_write_a[2], p0_l3.ready,
                p0_l3.rvalid});
    end
    checks++;
    if (mem_addr_a[2] !== 32'h0 || p0_l3.rdata !== 32'h0) begin
      failures++;
      $display("FAIL abort_bus got=%h/%h required=0/0", mem_addr_a[2], p0_l3.rdata);
    end
    p0_l3.req = 1'b0;
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (p0_l3.ready || p0_l3.rvalid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_resp got=%0d pulses required=0", seen);
    end
    p0_l3.req = 1'b1; p0_l3.addr = 32'h07;
    n = 0;
    do begin @(negedge clk); n++; end while (!p0_l3.ready && n < 10);
    checks++;
    if (n !== 4 || p0_l3.rvalid !== 1'b1 || p0_l3.rdata !== 32'h5A5A_0007) begin
      failures++;
      $display("FAIL after_reset got=%0d/%b/%h required=4/1/5a5a0007", n, p0_l3.rvalid,
               p0_l3.rdata);
    end
    p0_l3.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    p0_rr.req = 1'b0; p0_rr.we = 1'b0; p0_rr.addr = '0; p0_rr.wdata = '0;
    p1_rr.req = 1'b0; p1_rr.we = 1'b0; p1_rr.addr = '0; p1_rr.wdata = '0;
    p0_fp.req = 1'b0; p0_fp.we = 1'b0; p0_fp.addr = '0; p0_fp.wdata = '0;
    p1_fp.req = 1'b0; p1_fp.we = 1'b0; p1_fp.addr = '0; p1_fp.wdata = '0;
    p0_l3.req = 1'b0; p0_l3.we = 1'b0; p0_l3.addr = '0; p0_l3.wdata = '0;
    p1_l3.req = 1'b0; p1_l3.we = 1'b0; p1_l3.addr = '0; p1_l3.wdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_fixed_prio();
    test_latency3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
